// File: rtl/pc_fetch_if.sv
// Fetch-side bundle between the decode/control logic and the PC sequencer.
// The misalign flag is present only when PC_FETCH_MISALIGN_TRAP_EN is defined.
interface pc_fetch_if #(
    parameter int Width = 32
);
    logic             stall;
    logic             branch_taken;
    logic [Width-1:0] branch_target;
    logic             memcopy_start;
    logic [4:0]       memcopy_count;
    logic             mul_start;
    logic [Width-1:0] address;
    logic [Width-1:0] pc_plus4;
    logic             MemCopy1;
    logic             mul;
    logic             busy;
    logic [1:0]       dbg_state;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    logic             misalign;
`endif

    // Handshake: no valid/ready pair; decision inputs are sampled on every
    // rising clk edge and outputs are valid from just after that edge.
    modport master (
        output stall, branch_taken, branch_target, memcopy_start,
               memcopy_count, mul_start,
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        input  misalign,
`endif
        input  address, pc_plus4, MemCopy1, mul, busy, dbg_state
    );

    modport slave (
        input  stall, branch_taken, branch_target, memcopy_start,
               memcopy_count, mul_start,
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        output misalign,
`endif
        output address, pc_plus4, MemCopy1, mul, busy, dbg_state
    );
endinterface

// File: rtl/pc_fetch.sv
// Program counter sequencer with MemCopy replay and MUL hold states.
// Optional sticky misaligned-branch trap: define PC_FETCH_MISALIGN_TRAP_EN.
module pc_fetch #(
    parameter int Width      = 32,
    parameter int MUL_CYCLES = 4,
    parameter int ADDR_LIMIT = 512
) (
    input  logic        clk,
    input  logic        reset_n,
    pc_fetch_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MCOPY = 2'd1,
        ST_MULW  = 2'd2
    } state_t;

    localparam logic [Width-1:0] LIMIT = Width'(ADDR_LIMIT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [Width-1:0] r_address;
    logic [Width-1:0] w_address_nxt;
    logic [4:0]       r_count;
    logic [4:0]       w_count_nxt;
    logic             r_memcopy;
    logic             w_memcopy_nxt;
    logic             r_mul;
    logic             w_mul_nxt;
    logic [Width-1:0] w_incr;
    logic [Width-1:0] w_target;
    logic             w_frozen;
    logic             w_bad_target;

    // Sequential increment with wrap at the top of the instruction store.
    assign w_incr   = (r_address >= LIMIT - Width'(4)) ? '0 : r_address + Width'(4);
    assign w_target = (bus.branch_target % LIMIT) & ~Width'(3);

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    logic r_misalign;

    assign w_frozen     = r_misalign;
    assign w_bad_target = |bus.branch_target[1:0];
    assign bus.misalign = r_misalign;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_misalign <= 1'b0;
        end else if (r_state == ST_RUN && !r_misalign && bus.branch_taken && w_bad_target) begin
            r_misalign <= 1'b1;
        end
    end
`else
    assign w_frozen     = 1'b0;
    assign w_bad_target = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_RUN;
            r_address <= '0;
            r_count   <= '0;
            r_memcopy <= 1'b0;
            r_mul     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_address <= w_address_nxt;
            r_count   <= w_count_nxt;
            r_memcopy <= w_memcopy_nxt;
            r_mul     <= w_mul_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_address_nxt = r_address;
        w_count_nxt   = r_count;
        w_memcopy_nxt = r_memcopy;
        w_mul_nxt     = r_mul;
        case (r_state)
            ST_RUN: begin
                if (!w_frozen) begin
                    if (bus.branch_taken) begin
                        if (!w_bad_target) begin
                            w_address_nxt = w_target;
                        end
                    end else if (bus.memcopy_start) begin
                        w_state_nxt   = ST_MCOPY;
                        w_count_nxt   = (bus.memcopy_count == 5'd0) ? 5'd1 : bus.memcopy_count;
                        w_memcopy_nxt = 1'b1;
                    end else if (bus.mul_start) begin
                        w_state_nxt   = ST_MULW;
                        w_count_nxt   = 5'(MUL_CYCLES);
                        w_memcopy_nxt = 1'b1;
                        w_mul_nxt     = 1'b1;
                    end else if (!bus.stall) begin
                        w_address_nxt = w_incr;
                    end
                end
            end
            ST_MCOPY, ST_MULW: begin
                // Hold phase: all decision inputs are ignored until the count expires.
                if (r_count <= 5'd1) begin
                    w_state_nxt   = ST_RUN;
                    w_count_nxt   = 5'd0;
                    w_memcopy_nxt = 1'b0;
                    w_mul_nxt     = 1'b0;
                    w_address_nxt = w_incr;
                end else begin
                    w_count_nxt = r_count - 5'd1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign bus.address   = r_address;
    assign bus.pc_plus4  = w_incr;
    assign bus.MemCopy1  = r_memcopy;
    assign bus.mul       = r_mul;
    assign bus.busy      = (r_state != ST_RUN);
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_pc_fetch.sv
// Directed testbench for pc_fetch with hand-computed expected values.
// Build with PC_FETCH_MISALIGN_TRAP_EN defined to exercise the misalign trap.
module tb_pc_fetch;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    pc_fetch_if #(.Width(32)) bus ();

    pc_fetch #(
        .Width      (32),
        .MUL_CYCLES (4),
        .ADDR_LIMIT (512)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic br, input logic [31:0] tgt, input logic mc,
                         input logic [4:0] cnt, input logic ml, input logic st);
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        bus.memcopy_start = mc;
        bus.memcopy_count = cnt;
        bus.mul_start     = ml;
        bus.stall         = st;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        idle();
        tick();
        tick();
        check("rst_addr", bus.address, 32'd0);
        check("rst_mc", {31'd0, bus.MemCopy1}, 32'd0);
        check("rst_mul", {31'd0, bus.mul}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        reset_n = 1'b1;
        check("run_addr0", bus.address, 32'd0);

        // Free-running increment after reset release
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("run_addr", bus.address, 32'(4 * k));
            check("run_mc", {31'd0, bus.MemCopy1}, 32'd0);
            check("run_busy", {31'd0, bus.busy}, 32'd0);
        end

        // MemCopy of 3 at address 8; stall during the hold is ignored
        drive(1'b1, 32'd8, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        check("br8_addr", bus.address, 32'd8);
        drive(1'b0, 32'd0, 1'b1, 5'd3, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        check("mcopy_state", {30'd0, bus.dbg_state}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("mcopy_mc", {31'd0, bus.MemCopy1}, 32'd1);
            check("mcopy_busy", {31'd0, bus.busy}, 32'd1);
            check("mcopy_addr", bus.address, 32'd8);
            tick();
        end
        idle();
        check("mcopy_end_mc", {31'd0, bus.MemCopy1}, 32'd0);
        check("mcopy_end_busy", {31'd0, bus.busy}, 32'd0);
        check("mcopy_end_addr", bus.address, 32'd12);

        // MUL hold at address 20 with a branch pulse that must be ignored
        drive(1'b1, 32'd20, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            check("mulw_mul", {31'd0, bus.mul}, 32'd1);
            check("mulw_mc", {31'd0, bus.MemCopy1}, 32'd1);
            check("mulw_addr", bus.address, 32'd20);
            if (i == 1) drive(1'b1, 32'h100, 1'b0, 5'd0, 1'b0, 1'b0);
            else idle();
            tick();
        end
        idle();
        check("mulw_end_mul", {31'd0, bus.mul}, 32'd0);
        check("mulw_end_mc", {31'd0, bus.MemCopy1}, 32'd0);
        check("mulw_end_addr", bus.address, 32'd24);

        // Wrap at the top of the store
        drive(1'b1, 32'd508, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        idle();
        check("wrap_pre_addr", bus.address, 32'd508);
        check("wrap_pre_pc4", bus.pc_plus4, 32'd0);
        tick();
        check("wrap_addr", bus.address, 32'd0);
        check("wrap_pc4", bus.pc_plus4, 32'd4);

        // Stall holds, then increment resumes
        drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        tick();
        check("stall_addr", bus.address, 32'd0);
        idle();
        tick();
        check("unstall_addr", bus.address, 32'd4);

        // MemCopy count 0 behaves as 1
        drive(1'b0, 32'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        tick();
        idle();
        check("mc0_mc", {31'd0, bus.MemCopy1}, 32'd1);
        check("mc0_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        check("mc0_end_mc", {31'd0, bus.MemCopy1}, 32'd0);
        check("mc0_end_addr", bus.address, 32'd8);

        // memcopy_start outranks mul_start
        drive(1'b0, 32'd0, 1'b1, 5'd1, 1'b1, 1'b0);
        tick();
        idle();
        check("prio_mc", {31'd0, bus.MemCopy1}, 32'd1);
        check("prio_mul", {31'd0, bus.mul}, 32'd0);
        check("prio_state", {30'd0, bus.dbg_state}, 32'd1);
        tick();
        check("prio_end_addr", bus.address, 32'd12);

        // branch_taken outranks memcopy_start
        drive(1'b1, 32'h40, 1'b1, 5'd3, 1'b0, 1'b0);
        tick();
        idle();
        check("brmc_addr", bus.address, 32'h40);
        check("brmc_busy", {31'd0, bus.busy}, 32'd0);
        check("brmc_mc", {31'd0, bus.MemCopy1}, 32'd0);
        tick();
        check("brmc_next", bus.address, 32'h44);

        // Asynchronous reset in the second MCOPY cycle
        drive(1'b0, 32'd0, 1'b1, 5'd3, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        check("mid_busy", {31'd0, bus.busy}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_addr", bus.address, 32'd0);
        check("arst_mc", {31'd0, bus.MemCopy1}, 32'd0);
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("arst_first", bus.address, 32'd4);

        // Unaligned, out-of-range branch target
        drive(1'b1, 32'h25A, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        idle();
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        check("mis_flag", {31'd0, bus.misalign}, 32'd1);
        check("mis_addr", bus.address, 32'd4);
        tick();
        check("mis_frozen", bus.address, 32'd4);
        drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        idle();
        check("mis_no_mul", {31'd0, bus.busy}, 32'd0);
        check("mis_still", {31'd0, bus.misalign}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mis_rst", {31'd0, bus.misalign}, 32'd0);
        reset_n = 1'b1;
`else
        check("unal_addr", bus.address, 32'h58);
        tick();
        check("unal_next", bus.address, 32'h5C);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter Width, 32, data/address width.
REQ-002 Parameter MUL_CYCLES, 4, cycles the instruction stream is held for a MUL (range 1..15).
REQ-003 Parameter ADDR_LIMIT, 512, byte size of instruction store; PC wraps at this value.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 stall  input  1  hold PC this cycle.
REQ-008 branch_taken  input  1  redirect PC to branch_target.
REQ-009 branch_target  input  Width  byte address of the branch destination.
REQ-010 memcopy_start  input  1  a MemCopy instruction was decoded.
REQ-011 memcopy_count  input  5  N, the number of copy cycles (0 treated as 1).
REQ-012 mul_start  input  1  a MUL instruction was decoded.
REQ-013 address  output  Width  byte fetch address to instruction memory.
REQ-014 pc_plus4  output  Width  address+4 with wrap, for link/return.
REQ-015 MemCopy1  output  1  instruction-memory replay enable.
REQ-016 mul  output  1  selects the MUL hold path in instruction memory.
REQ-017 busy  output  1  high in any state other than RUN.

Function
REQ-018 FSM states: RUN, MCOPY, MULW; the FSM SHALL be encoded in 2 bits.
REQ-019 In RUN, the per-cycle priority SHALL be: branch_taken, then memcopy_start, then mul_start, then stall, then increment.
REQ-020 RUN, branch_taken=1: address <= branch_target mod ADDR_LIMIT, with bits [1:0] forced to 0.
REQ-021 RUN, memcopy_start=1: address held; count <= max(memcopy_count,1); state -> MCOPY; MemCopy1 <= 1.
REQ-022 RUN, mul_start=1: address held; count <= MUL_CYCLES; state -> MULW; MemCopy1 <= 1; mul <= 1.
REQ-023 RUN, stall=1: address held; no other effect.
REQ-024 RUN, otherwise: address <= (address+4) mod ADDR_LIMIT.
REQ-025 Wrap-around: ADDR_LIMIT-4 followed by an increment SHALL give 0; pc_plus4 SHALL use the same wrap.
REQ-026 MCOPY and MULW: address held; count decrements by 1 per cycle.
REQ-027 MCOPY and MULW: branch_taken, memcopy_start, mul_start and stall SHALL be ignored.
REQ-028 When count reaches 1 in MCOPY or MULW: state -> RUN; MemCopy1 <= 0; mul <= 0; address <= address+4 (wrapped).
REQ-029 Total hold time: exactly N cycles for MCOPY and MUL_CYCLES cycles for MULW, not counting the entry cycle.
REQ-030 Latency: address is registered and changes one clk edge after the decision inputs are sampled.
REQ-031 MemCopy1 and mul SHALL be registered outputs with no combinational path from any input.
REQ-032 pc_plus4 SHALL be combinational from address.
REQ-033 busy SHALL be combinational from state.

Reset
REQ-034 reset_n=0 SHALL asynchronously force: address=0, state=RUN, count=0, MemCopy1=0, mul=0.
REQ-035 The reset of REQ-034 SHALL apply in any state, including in the middle of MCOPY or MULW.
REQ-036 After reset_n rises, the first rising clk edge SHALL evaluate RUN rules with address=0.

Configuration
REQ-037 The block SHALL provide macro PC_FETCH_MISALIGN_TRAP_EN.
REQ-038 With the macro defined, a taken branch whose branch_target[1:0] != 0 SHALL set output misalign (1 bit, sticky) and SHALL NOT change address.
REQ-039 With the macro defined, misalign SHALL clear only on reset, and while it is set the FSM SHALL hold in RUN with address frozen.
REQ-040 Without the macro, target bits [1:0] SHALL be silently cleared as in REQ-020, and the misalign port SHALL NOT exist.

Verification
REQ-041 Reset, then 5 free-running cycles -> address sequence 0,4,8,12,16,20; MemCopy1=0; busy=0.
REQ-042 address=508, one increment -> address=0 and pc_plus4=4.
REQ-043 At address=8, memcopy_start=1 with count=3 -> MemCopy1=1 and busy=1 for 3 cycles with address=8; then MemCopy1=0 and address=12.
REQ-044 At address=20, mul_start=1 with MUL_CYCLES=4 -> mul=1 and MemCopy1=1 for 4 cycles; a branch_taken pulse during the hold is ignored; then address=24.
REQ-045 reset_n asserted in the 2nd MCOPY cycle -> immediately address=0, MemCopy1=0, busy=0.
REQ-046 branch_taken and memcopy_start asserted together with target=0x40 -> address=0x40 and state stays RUN; with the macro defined, target=0x42 -> misalign=1 and address unchanged.
